cpu_data_sram_resp: RTL and testbench

CPU_DATA_SRAM_RESP -- requirements
Module: cpu_data_sram_resp

---
 rtl/cpu_data_sram_resp.sv | 157 +++++++++++++++
 tb/tb_cpu_data_sram_resp.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_data_sram_resp.sv
// cpu_data_sram_resp: data-side SRAM responder for a simple CPU bus.
// Word-addressed RAM with byte enables, read-first, and 1-cycle registered read data.
// Accesses whose upper address half matches MMIO_BASE[31:16] go to a small register window:
// SCRATCH (0x0), LED (0x4) and TIMER (0x8).
// Optional feature macro: CPU_RESP_TIMER_EN builds the free-running TIMER.
// Without it, offset 0x8 reads zero and ignores writes.
module cpu_data_sram_resp #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] MMIO_BASE  = 32'hBFAF_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Address decode
  logic                  is_mmio;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [13:0]           mmio_off;
  logic                  ram_en;
  logic                  mmio_hit;
  logic                  wr_scratch;
  logic                  wr_led;
  logic [31:0]           bit_mask;
  logic                  unused_addr_bits;

  assign is_mmio  = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign ram_idx  = data_sram_addr[ADDR_WIDTH+1:2];
  assign mmio_off = data_sram_addr[15:2];
  // The RAM write/read path has no reset of its own, so gating with resetn keeps
  // an access that overlaps reset assertion from committing.
  assign ram_en     = data_sram_en & ~is_mmio & resetn;
  assign mmio_hit   = data_sram_en & is_mmio;
  assign wr_scratch = mmio_hit & (mmio_off == 14'd0);
  assign wr_led     = mmio_hit & (mmio_off == 14'd1);
  // Byte lane bits [1:0] of the address carry no meaning on a word bus.
  assign unused_addr_bits = ^data_sram_addr[1:0];

  genvar gi;

  // Expand the per-byte write enables into a per-bit mask.
  for (gi = 0; gi < 4; gi++) begin : g_mask
    assign bit_mask[8*gi +: 8] = {8{data_sram_we[gi]}};
  end

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  // RAM: one memory per byte lane so each lane maps onto a plain block RAM.
  logic [31:0] ram_q;

  for (gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [0:DEPTH-1];
    logic [7:0] q_reg;

    // Read-first byte lane: the old contents are captured in the same edge that writes.
    always_ff @(posedge clk) begin
      if (ram_en) begin
        q_reg <= mem[ram_idx];
        if (data_sram_we[gi]) begin
          mem[ram_idx] <= data_sram_wdata[8*gi +: 8];
        end
      end
    end

    assign ram_q[8*gi +: 8] = q_reg;
  end

  // MMIO registers
  logic [31:0] scratch_reg;
  logic [31:0] scratch_next;
  logic [15:0] led_reg;
  logic [15:0] led_next;
  logic [31:0] timer_val;

  assign scratch_next = merge_bytes(scratch_reg, data_sram_wdata, bit_mask);
  assign led_next     = (led_reg & ~bit_mask[15:0]) | (data_sram_wdata[15:0] & bit_mask[15:0]);
  assign led          = led_reg;

  // SCRATCH and LED update on their own write strobes only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scratch_reg <= '0;
      led_reg     <= '0;
    end else begin
      if (wr_scratch) scratch_reg <= scratch_next;
      if (wr_led)     led_reg     <= led_next;
    end
  end

`ifdef CPU_RESP_TIMER_EN
  logic        wr_timer;
  logic [31:0] timer_reg;
  logic [31:0] timer_next;

  assign wr_timer  = mmio_hit & (mmio_off == 14'd2);
  assign timer_val = timer_reg;

  // A bus write replaces that cycle's increment; counting resumes on the next edge.
  always_comb begin
    timer_next = timer_reg + 32'd1;
    if (wr_timer) timer_next = merge_bytes(timer_reg, data_sram_wdata, bit_mask);
  end

  // Free-running counter, wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) timer_reg <= '0;
    else         timer_reg <= timer_next;
  end
`else
  assign timer_val = '0;
`endif

  // MMIO read mux sees register values from before this cycle's update.
  logic [31:0] mmio_rd;

  always_comb begin
    mmio_rd = '0;
    case (mmio_off)
      14'd0:   mmio_rd = scratch_reg;
      14'd1:   mmio_rd = {16'h0000, led_reg};
      14'd2:   mmio_rd = timer_val;
      default: mmio_rd = '0;
    endcase
  end

  // Read-side bookkeeping: which source feeds rdata, and whether any access happened since reset.
  logic        rvalid_reg;
  logic        rmmio_reg;
  logic [31:0] mmio_q_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rvalid_reg <= 1'b0;
      rmmio_reg  <= 1'b0;
      mmio_q_reg <= '0;
    end else if (data_sram_en) begin
      rvalid_reg <= 1'b1;
      rmmio_reg  <= is_mmio;
      if (is_mmio) mmio_q_reg <= mmio_rd;
    end
  end

  // rvalid_reg masks the unreset RAM output register so rdata is 0 during and after reset.
  assign data_sram_rdata = !rvalid_reg ? 32'h0 : (rmmio_reg ? mmio_q_reg : ram_q);

endmodule

// File: tb/tb_cpu_data_sram_resp.sv
// Self-checking bench for cpu_data_sram_resp: directed scenarios plus randomized traffic
// compared against a behavioural model of the RAM and register window.
module tb_cpu_data_sram_resp;

  logic        clk;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [15:0] led;

  int checks   = 0;
  int failures = 0;

  cpu_data_sram_resp #(.ADDR_WIDTH(12), .MMIO_BASE(32'hBFAF_0000)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .led             (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model
  logic [31:0] ram_m [4096];
  bit          ram_known [4096];
  logic [31:0] scratch_m;
  logic [15:0] led_m;
  logic [31:0] timer_m;
  logic [31:0] exp_rdata;
  bit          exp_known;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] we);
    for (int i = 0; i < 4; i++) if (we[i]) o[8*i +: 8] = n[8*i +: 8];
    return o;
  endfunction

  function automatic bit is_mmio_addr(input logic [31:0] a);
    return a[31:16] == 16'hBFAF;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [11:0] idx;
    idx = a[13:2];
    if (is_mmio_addr(a)) begin
      case (a[15:2])
        14'd0: return scratch_m;
        14'd1: return {16'h0000, led_m};
`ifdef CPU_RESP_TIMER_EN
        14'd2: return timer_m;
`endif
        default: return 32'h0;
      endcase
    end
    return ram_m[idx];
  endfunction

  // One bus cycle: drive at negedge, update model, sample 1ns after the rising edge.
  task automatic cyc(input bit en, input logic [3:0] we, input logic [31:0] addr,
                     input logic [31:0] wd, input string name, input bit verbose);
    logic [11:0] idx;
    logic [31:0] tmp;
    bit          timer_wr;
    @(negedge clk);
    data_sram_en    = en;
    data_sram_we    = we;
    data_sram_addr  = addr;
    data_sram_wdata = wd;
    idx      = addr[13:2];
    timer_wr = 1'b0;
    if (en) begin
      exp_rdata = model_read(addr);
      exp_known = is_mmio_addr(addr) ? 1'b1 : ram_known[idx];
      if (is_mmio_addr(addr)) begin
        case (addr[15:2])
          14'd0: scratch_m = merge(scratch_m, wd, we);
          14'd1: begin
            tmp   = merge({16'h0000, led_m}, wd, we);
            led_m = tmp[15:0];
          end
          14'd2: begin
            timer_wr = 1'b1;
            timer_m  = merge(timer_m, wd, we);
          end
          default: ;
        endcase
      end else if (we == 4'hF) begin
        ram_m[idx]     = wd;
        ram_known[idx] = 1'b1;
      end else if (we != 4'h0) begin
        ram_m[idx] = merge(ram_m[idx], wd, we);
      end
    end
    if (!timer_wr) timer_m = timer_m + 32'd1;
    @(posedge clk);
    #1;
    if (exp_known) begin
      checks++;
      if (data_sram_rdata !== exp_rdata) begin
        failures++;
        $display("FAIL %s rdata got=%08h exp=%08h", name, data_sram_rdata, exp_rdata);
      end
    end
    checks++;
    if (led !== led_m) begin
      failures++;
      $display("FAIL %s led got=%04h exp=%04h", name, led, led_m);
    end
    if (verbose)
      $display("txn %-12s en=%0d we=%h addr=%08h wdata=%08h rdata=%08h led=%04h",
               name, en, we, addr, wd, data_sram_rdata, led);
  endtask

  task automatic model_reset();
    scratch_m = 32'h0;
    led_m     = 16'h0;
    timer_m   = 32'h0;
    exp_rdata = 32'h0;
    exp_known = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    data_sram_en = 1'b0; data_sram_we = 4'h0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
    for (int i = 0; i < 4096; i++) ram_known[i] = 1'b0;
    #1 resetn = 1'b0;
    #1;
    checks++;
    if (data_sram_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_rdata got=%08h exp=00000000", data_sram_rdata);
    end
    checks++;
    if (led !== 16'h0) begin
      failures++; $display("FAIL reset_led got=%04h exp=0000", led);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    model_reset();
    cyc(1'b0, 4'h0, 32'h0, 32'h0, "idle_post_rst", 1'b1);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4096; i++)
      cyc(1'b1, 4'hF, i << 2, $urandom, "fill", 1'b0);
    cyc(1'b0, 4'h0, 32'h0, 32'h0, "fill_done", 1'b1);
  endtask

  task automatic test_ram_directed();
    cyc(1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, "wr_100", 1'b1);
    cyc(1'b1, 4'h0, 32'h0000_0100, 32'h0, "rd_100", 1'b1);
    checks++;
    if (data_sram_rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL b2b_rd_100 got=%08h exp=deadbeef", data_sram_rdata);
    end
    cyc(1'b1, 4'hF, 32'h0000_0104, 32'h1122_3344, "wr_104", 1'b1);
    cyc(1'b1, 4'b0101, 32'h0000_0104, 32'hAABB_CCDD, "pwr_104", 1'b1);
    checks++;
    if (data_sram_rdata !== 32'h1122_3344) begin
      failures++; $display("FAIL read_first_104 got=%08h exp=11223344", data_sram_rdata);
    end
    cyc(1'b0, 4'h0, 32'h0, 32'h0, "idle", 1'b1);
    cyc(1'b1, 4'h0, 32'h0000_0104, 32'h0, "rd_104", 1'b1);
    checks++;
    if (data_sram_rdata !== 32'h11BB_33DD) begin
      failures++; $display("FAIL byte_merge_104 got=%08h exp=11bb33dd", data_sram_rdata);
    end
    cyc(1'b1, 4'hF, 32'h0000_4000, 32'h0000_005A, "wr_alias", 1'b1);
    cyc(1'b1, 4'h0, 32'h0000_0000, 32'h0, "rd_alias", 1'b1);
    checks++;
    if (data_sram_rdata !== 32'h0000_005A) begin
      failures++; $display("FAIL alias_rd_0 got=%08h exp=0000005a", data_sram_rdata);
    end
    // Writes with en=0 must not land, and rdata must hold.
    cyc(1'b0, 4'hF, 32'h0000_0000, 32'hFFFF_FFFF, "ghost_wr", 1'b1);
    cyc(1'b1, 4'h0, 32'h0000_0000, 32'h0, "rd_after_ghost", 1'b1);
  endtask

  task automatic test_mmio();
    cyc(1'b1, 4'hF, 32'hBFAF_0004, 32'h1234_ABCD, "wr_led", 1'b1);
    checks++;
    if (led !== 16'hABCD) begin
      failures++; $display("FAIL led_value got=%04h exp=abcd", led);
    end
    cyc(1'b1, 4'h0, 32'hBFAF_0004, 32'h0, "rd_led", 1'b1);
    checks++;
    if (data_sram_rdata !== 32'h0000_ABCD) begin
      failures++; $display("FAIL rd_led got=%08h exp=0000abcd", data_sram_rdata);
    end
    cyc(1'b1, 4'hF, 32'hBFAF_000C, 32'h5555_5555, "wr_off_c", 1'b1);
    cyc(1'b1, 4'h0, 32'hBFAF_000C, 32'h0, "rd_off_c", 1'b1);
    checks++;
    if (data_sram_rdata !== 32'h0) begin
      failures++; $display("FAIL rd_off_c got=%08h exp=00000000", data_sram_rdata);
    end
    cyc(1'b1, 4'hF, 32'hBFAF_0000, 32'hCAFE_0001, "wr_scratch", 1'b1);
    cyc(1'b1, 4'b1010, 32'hBFAF_0000, 32'h1122_3344, "pwr_scratch", 1'b1);
    cyc(1'b1, 4'h0, 32'hBFAF_0000, 32'h0, "rd_scratch", 1'b1);
  endtask

  task automatic test_timer();
    logic [31:0] e0, e1, e2;
`ifdef CPU_RESP_TIMER_EN
    e0 = 32'hFFFF_FFFE; e1 = 32'hFFFF_FFFF; e2 = 32'h0;
`else
    e0 = 32'h0; e1 = 32'h0; e2 = 32'h0;
`endif
    cyc(1'b1, 4'hF, 32'hBFAF_0008, 32'hFFFF_FFFE, "wr_timer", 1'b1);
    cyc(1'b1, 4'h0, 32'hBFAF_0008, 32'h0, "rd_timer0", 1'b1);
    checks++;
    if (data_sram_rdata !== e0) begin
      failures++; $display("FAIL timer0 got=%08h exp=%08h", data_sram_rdata, e0);
    end
    cyc(1'b1, 4'h0, 32'hBFAF_0008, 32'h0, "rd_timer1", 1'b1);
    checks++;
    if (data_sram_rdata !== e1) begin
      failures++; $display("FAIL timer1 got=%08h exp=%08h", data_sram_rdata, e1);
    end
    cyc(1'b1, 4'h0, 32'hBFAF_0008, 32'h0, "rd_timer2", 1'b1);
    checks++;
    if (data_sram_rdata !== e2) begin
      failures++; $display("FAIL timer2 got=%08h exp=%08h", data_sram_rdata, e2);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    bit          en;
    for (int n = 0; n < 400; n++) begin
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0)
        a = 32'hBFAF_0000 | ($urandom_range(0, 5) << 2) | $urandom_range(0, 3);
      else
        a = ($urandom & 32'h7FFF_C000) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      cyc(en, 4'($urandom), a, $urandom, "random", 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 4'hF, 32'h0000_0200, 32'h0BAD_F00D, "pre_wr_200", 1'b1);
    cyc(1'b1, 4'hF, 32'hBFAF_0000, 32'h7777_7777, "pre_scratch", 1'b1);
    cyc(1'b1, 4'hF, 32'hBFAF_0004, 32'h0000_5A5A, "pre_led", 1'b1);
    cyc(1'b1, 4'h0, 32'hBFAF_0000, 32'h0, "pre_rd", 1'b1);
    @(negedge clk);
    data_sram_en = 1'b1; data_sram_we = 4'hF;
    data_sram_addr = 32'h0000_0200; data_sram_wdata = 32'hCAFE_F00D;
    #1 resetn = 1'b0;
    #1;
    checks++;
    if (data_sram_rdata !== 32'h0) begin
      failures++; $display("FAIL midrst_rdata got=%08h exp=00000000", data_sram_rdata);
    end
    checks++;
    if (led !== 16'h0) begin
      failures++; $display("FAIL midrst_led got=%04h exp=0000", led);
    end
    @(posedge clk);
    #1;
    checks++;
    if (data_sram_rdata !== 32'h0) begin
      failures++; $display("FAIL midrst_edge got=%08h exp=00000000", data_sram_rdata);
    end
    @(negedge clk);
    data_sram_en = 1'b0; data_sram_we = 4'h0;
    resetn = 1'b1;
    model_reset();
    $display("txn %-12s resetn pulsed with write in flight", "mid_reset");
    cyc(1'b1, 4'h0, 32'h0000_0200, 32'h0, "post_rd_200", 1'b1);
    checks++;
    if (data_sram_rdata !== 32'h0BAD_F00D) begin
      failures++; $display("FAIL ram_kept got=%08h exp=0badf00d", data_sram_rdata);
    end
    cyc(1'b1, 4'h0, 32'hBFAF_0000, 32'h0, "post_scratch", 1'b1);
    checks++;
    if (data_sram_rdata !== 32'h0) begin
      failures++; $display("FAIL scratch_cleared got=%08h exp=00000000", data_sram_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_ram_directed();
    test_mmio();
    test_timer();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
